// File: rtl/ddr_test_csr_mc.sv
// rtl/ddr_test_csr_mc.sv - AXI4-Lite CSR block for the multi-channel DDR BIST
module ddr_test_csr_mc #(
  parameter int          NUM_CH      = 4,
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] REQ_LEN_RST = 32'h0040_0000,
  parameter logic [31:0] VERSION     = 32'h00F5_0020,
  parameter logic [31:0] BUILD_DATE  = 32'h2111_2300
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NUM_CH-1:0]       prbs_mode_start,
  output logic [4*NUM_CH-1:0]     prbs_mode_sel,
  output logic [32*NUM_CH-1:0]    req_len,
  input  logic [NUM_CH-1:0]       bist_running,
  input  logic [NUM_CH-1:0]       bist_cplt,
  input  logic [NUM_CH-1:0]       bist_err,
  input  logic [32*NUM_CH-1:0]    err_cnt,
  input  logic [32*NUM_CH-1:0]    txcmd_cnt,
  input  logic [32*NUM_CH-1:0]    rxcmd_cnt,
  input  logic [64*NUM_CH-1:0]    round_time,
  input  logic                    ddr_cal_done,
  output logic [NUM_CH-1:0]       usr_int_req,
  input  logic [NUM_CH-1:0]       usr_int_ack
);

  localparam logic [ADDR_WIDTH-1:0] CH_BASE = ADDR_WIDTH'(256);
  localparam logic [ADDR_WIDTH-1:0] CH_END  = ADDR_WIDTH'(256 + NUM_CH * 64);
  localparam logic [ADDR_WIDTH-1:0] GLB_END = ADDR_WIDTH'(32);

  // Write/read channel handshake state
  logic                  awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  arready_q, ar_held_q, rvalid_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [31:0]           rdata_q;

  // Register file
  logic [NUM_CH-1:0] start_q, start_d;
  logic [3:0]        sel_q [NUM_CH];
  logic [3:0]        sel_d [NUM_CH];
  logic [31:0]       req_len_q [NUM_CH];
  logic [31:0]       req_len_d [NUM_CH];
  logic [31:0]       rt_shadow_q [NUM_CH];
  logic [NUM_CH-1:0] int_en_q, int_en_d, int_status_q, int_status_d;
  logic [NUM_CH-1:0] err_sticky_q, err_sticky_d, cplt_prev_q, int_req_q;
  logic [31:0]       scratch_q, scratch_d;
  logic              soft_clr_q, soft_clr_d;
  logic [1:0]        cal_sync_q;

  // Decode helpers
  logic [ADDR_WIDTH-1:0] wa, woff, ra, roff;
  logic [2:0]            wch, rch;
  logic [3:0]            wreg, rreg;
  logic                  w_glb, w_chn, r_glb, r_chn, wr_err, wr_fire, wr_ok;
  logic [NUM_CH-1:0]     w1c, force_set, int_clr;
  logic [31:0]           rd_data;
  logic                  rd_err;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    merge = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merge[8*b +: 8] = new_v[8*b +: 8];
    end
  endfunction

  // Decode the held write address; read-only and unmapped targets error out
  always_comb begin
    wa    = {aw_addr_q[ADDR_WIDTH-1:2], 2'b00};
    woff  = wa - CH_BASE;
    wch   = woff[8:6];
    wreg  = woff[5:2];
    w_glb = (wa < GLB_END);
    w_chn = (wa >= CH_BASE) && (wa < CH_END);
    wr_err = 1'b1;
    if (w_glb) begin
      wr_err = (wa[4:2] == 3'd0) || (wa[4:2] == 3'd1) || (wa[4:2] == 3'd3);
    end else if (w_chn) begin
      wr_err = (wreg > 4'd1);
    end
    wr_fire = aw_held_q && w_held_q && !bvalid_q;
    wr_ok   = wr_fire && !wr_err;
  end

  // Register next-state: host writes, interrupt set/clear, error stickiness
  always_comb begin
    start_d    = start_q;
    int_en_d   = int_en_q;
    scratch_d  = scratch_q;
    soft_clr_d = 1'b0;
    w1c        = '0;
    force_set  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_d[c]     = sel_q[c];
      req_len_d[c] = req_len_q[c];
    end
    if (wr_ok) begin
      if (w_glb) begin
        case (wa[4:2])
          3'd2: if (w_strb_q[0]) soft_clr_d = w_data_q[0];
          3'd4: if (w_strb_q[0]) int_en_d = w_data_q[NUM_CH-1:0];
          3'd5: if (w_strb_q[0]) w1c = w_data_q[NUM_CH-1:0];
          3'd6: if (w_strb_q[0]) force_set = w_data_q[NUM_CH-1:0];
          3'd7: scratch_d = merge(scratch_q, w_data_q, w_strb_q);
          default: ;
        endcase
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (wch == 3'(c)) begin
            if (wreg == 4'd0 && w_strb_q[0]) begin
              start_d[c] = w_data_q[0];
              sel_d[c]   = w_data_q[7:4];
            end else if (wreg == 4'd1) begin
              req_len_d[c] = merge(req_len_q[c], w_data_q, w_strb_q);
            end
          end
        end
      end
    end
    // Set sources are OR'd in last so they win over any coincident clear
    int_clr      = w1c | usr_int_ack | {NUM_CH{soft_clr_q}};
    int_status_d = (int_status_q & ~int_clr) | (bist_cplt & ~cplt_prev_q) | force_set;
    err_sticky_d = (err_sticky_q & ~{NUM_CH{soft_clr_q}}) | bist_err;
  end

  // Read data mux, evaluated from the held read address
  always_comb begin
    ra     = {ar_addr_q[ADDR_WIDTH-1:2], 2'b00};
    roff   = ra - CH_BASE;
    rch    = roff[8:6];
    rreg   = roff[5:2];
    r_glb  = (ra < GLB_END);
    r_chn  = (ra >= CH_BASE) && (ra < CH_END);
    rd_data = '0;
    rd_err  = 1'b0;
    if (r_glb) begin
      case (ra[4:2])
        3'd0: rd_data = VERSION;
        3'd1: rd_data = BUILD_DATE;
        3'd2: rd_data = {31'd0, soft_clr_q};
        3'd3: rd_data = {31'd0, cal_sync_q[1]};
        3'd4: rd_data = 32'(int_en_q);
        3'd5: rd_data = 32'(int_status_q);
        3'd6: rd_data = '0;
        default: rd_data = scratch_q;
      endcase
    end else if (r_chn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rch == 3'(c)) begin
          case (rreg)
            4'd0: rd_data = {24'd0, sel_q[c], 3'd0, start_q[c]};
            4'd1: rd_data = req_len_q[c];
            4'd2: rd_data = {29'd0, err_sticky_q[c], bist_cplt[c], bist_running[c]};
            4'd3: rd_data = err_cnt[32*c +: 32];
            4'd4: rd_data = txcmd_cnt[32*c +: 32];
            4'd5: rd_data = rxcmd_cnt[32*c +: 32];
            4'd6: rd_data = round_time[64*c +: 32];
            4'd7: rd_data = rt_shadow_q[c];
            default: rd_err = 1'b1;
          endcase
        end
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  // Write channel: independent AW/W capture, single outstanding B response
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (s_axi_awvalid && awready_q) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
        awready_q <= 1'b0;
      end
      if (s_axi_wvalid && wready_q) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
        wready_q <= 1'b0;
      end
      if (wr_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? 2'b10 : 2'b00;
      end
      if (bvalid_q && s_axi_bready) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
    end
  end

  // Read channel: capture AR, present data one cycle later, hold until rready
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      arready_q <= 1'b1;
      ar_held_q <= 1'b0;
      ar_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      if (s_axi_arvalid && arready_q) begin
        ar_held_q <= 1'b1;
        ar_addr_q <= s_axi_araddr;
        arready_q <= 1'b0;
      end
      if (ar_held_q) begin
        ar_held_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_data;
        rresp_q   <= rd_err ? 2'b10 : 2'b00;
      end
      if (rvalid_q && s_axi_rready) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end
    end
  end

  // Register file state, RT_HI shadow capture and interrupt output
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      start_q      <= '0;
      int_en_q     <= '0;
      int_status_q <= '0;
      err_sticky_q <= '0;
      cplt_prev_q  <= '0;
      int_req_q    <= '0;
      scratch_q    <= '0;
      soft_clr_q   <= 1'b0;
      cal_sync_q   <= 2'b00;
      for (int c = 0; c < NUM_CH; c++) begin
        sel_q[c]       <= '0;
        req_len_q[c]   <= REQ_LEN_RST;
        rt_shadow_q[c] <= '0;
      end
    end else begin
      start_q      <= start_d;
      int_en_q     <= int_en_d;
      int_status_q <= int_status_d;
      err_sticky_q <= err_sticky_d;
      cplt_prev_q  <= bist_cplt;
      int_req_q    <= int_status_q & int_en_q;
      scratch_q    <= scratch_d;
      soft_clr_q   <= soft_clr_d;
      cal_sync_q   <= {cal_sync_q[0], ddr_cal_done};
      for (int c = 0; c < NUM_CH; c++) begin
        sel_q[c]     <= sel_d[c];
        req_len_q[c] <= req_len_d[c];
        if (ar_held_q && r_chn && rreg == 4'd6 && rch == 3'(c)) begin
          rt_shadow_q[c] <= round_time[64*c+32 +: 32];
        end
      end
    end
  end

  // Flatten per-channel control registers onto the output buses
  always_comb begin
    prbs_mode_sel = '0;
    req_len       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prbs_mode_sel[4*c +: 4] = sel_q[c];
      req_len[32*c +: 32]     = req_len_q[c];
    end
  end

  assign prbs_mode_start = start_q;
  assign usr_int_req     = int_req_q;
  assign s_axi_awready   = awready_q;
  assign s_axi_wready    = wready_q;
  assign s_axi_bvalid    = bvalid_q;
  assign s_axi_bresp     = bresp_q;
  assign s_axi_arready   = arready_q;
  assign s_axi_rvalid    = rvalid_q;
  assign s_axi_rresp     = rresp_q;
  assign s_axi_rdata     = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{aw_addr_q[1:0], ar_addr_q[1:0], woff[ADDR_WIDTH-1:9], roff[ADDR_WIDTH-1:9]};

endmodule

// File: tb/tb_ddr_test_csr_mc.sv
// tb/tb_ddr_test_csr_mc.sv - directed self-checking bench for ddr_test_csr_mc
module tb_ddr_test_csr_mc;

  logic         s_axi_aclk = 1'b0;
  logic         s_axi_aresetn;
  logic [11:0]  s_axi_awaddr;
  logic         s_axi_awvalid, s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid, s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid, s_axi_bready;
  logic [11:0]  s_axi_araddr;
  logic         s_axi_arvalid, s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid, s_axi_rready;
  logic [3:0]   prbs_mode_start;
  logic [15:0]  prbs_mode_sel;
  logic [127:0] req_len;
  logic [3:0]   bist_running, bist_cplt, bist_err;
  logic [127:0] err_cnt, txcmd_cnt, rxcmd_cnt;
  logic [255:0] round_time;
  logic         ddr_cal_done;
  logic [3:0]   usr_int_req, usr_int_ack;

  int tests = 0;
  int fails = 0;

  always #5 s_axi_aclk = ~s_axi_aclk;

  ddr_test_csr_mc dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .prbs_mode_start(prbs_mode_start), .prbs_mode_sel(prbs_mode_sel), .req_len(req_len),
    .bist_running(bist_running), .bist_cplt(bist_cplt), .bist_err(bist_err),
    .err_cnt(err_cnt), .txcmd_cnt(txcmd_cnt), .rxcmd_cnt(rxcmd_cnt),
    .round_time(round_time), .ddr_cal_done(ddr_cal_done),
    .usr_int_req(usr_int_req), .usr_int_ack(usr_int_ack)
  );

  // Returns at the first negedge where bvalid is seen; B completes on the next posedge if bready=1
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit w_lead, output logic [1:0] resp);
    int n;
    @(negedge s_axi_aclk);
    if (w_lead) begin
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      @(negedge s_axi_aclk);
      s_axi_wvalid = 1'b0;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    end else begin
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    end
    @(negedge s_axi_aclk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(negedge s_axi_aclk); n++; end
    tests++;
    if (!s_axi_bvalid) begin
      fails++; $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, s_axi_bvalid);
    end
    resp = s_axi_bresp;
  endtask

  // Returns at the negedge where rvalid is seen; lat counts negedges after the AR handshake
  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
    int n;
    @(negedge s_axi_aclk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(negedge s_axi_aclk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge s_axi_aclk); n++; end
    tests++;
    if (!s_axi_rvalid) begin
      fails++; $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, s_axi_rvalid);
    end
    d = s_axi_rdata; r = s_axi_rresp; lat = n;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat;
    tests++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b11100) begin
      fails++; $display("FAIL reset_handshake got=%b required 11100",
        {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    tests++;
    if ({s_axi_rdata, s_axi_rresp, s_axi_bresp, usr_int_req, prbs_mode_start, prbs_mode_sel} !== '0) begin
      fails++; $display("FAIL reset_outputs rdata=%h rresp=%b bresp=%b int=%b start=%b sel=%h required 0",
        s_axi_rdata, s_axi_rresp, s_axi_bresp, usr_int_req, prbs_mode_start, prbs_mode_sel);
    end
    tests++;
    if (req_len !== {4{32'h0040_0000}}) begin
      fails++; $display("FAIL reset_req_len got=%h required 4x00400000", req_len);
    end
    axi_read(12'h000, d, r, lat);
    tests++;
    if (d !== 32'h00F5_0020 || r !== 2'b00) begin
      fails++; $display("FAIL rd_version got=%h/%b required 00f50020/00", d, r);
    end
    tests++;
    if (lat !== 1) begin
      fails++; $display("FAIL rd_latency got=%0d required 1", lat);
    end
    axi_read(12'h104, d, r, lat);
    tests++;
    if (d !== 32'h0040_0000 || r !== 2'b00) begin
      fails++; $display("FAIL rd_req_len1 got=%h/%b required 00400000/00", d, r);
    end
    axi_read(12'h00C, d, r, lat);
    tests++;
    if (d !== 32'h1) begin
      fails++; $display("FAIL rd_cal got=%h required 1", d);
    end
  endtask

  task automatic test_write_strobes();
    logic [31:0] d; logic [1:0] r, b; int lat;
    axi_write(12'h140, 32'h0000_0031, 4'b0001, 1'b1, b);
    tests++;
    if (b !== 2'b00 || prbs_mode_start !== 4'b0010 || prbs_mode_sel[7:4] !== 4'h3) begin
      fails++; $display("FAIL wr_ctrl1 bresp=%b start=%b sel1=%h required 00/0010/3",
        b, prbs_mode_start, prbs_mode_sel[7:4]);
    end
    axi_write(12'h144, 32'hAABB_CCDD, 4'b0101, 1'b0, b);
    tests++;
    if (b !== 2'b00 || req_len[63:32] !== 32'h00BB_00DD) begin
      fails++; $display("FAIL wr_strb_req_len bresp=%b got=%h required 00/00bb00dd", b, req_len[63:32]);
    end
    axi_read(12'h140, d, r, lat);
    tests++;
    if (d !== 32'h0000_0031 || r !== 2'b00) begin
      fails++; $display("FAIL rd_ctrl1 got=%h/%b required 00000031/00", d, r);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r, b; int lat;
    axi_write(12'h204, 32'hFFFF_FFFF, 4'b1111, 1'b0, b);
    tests++;
    if (b !== 2'b10 || req_len !== {32'h0040_0000, 32'h0040_0000, 32'h00BB_00DD, 32'h0040_0000}) begin
      fails++; $display("FAIL wr_unmapped bresp=%b req_len=%h required 10/unchanged", b, req_len);
    end
    axi_read(12'h200, d, r, lat);
    tests++;
    if (d !== 32'h0 || r !== 2'b10) begin
      fails++; $display("FAIL rd_unmapped got=%h/%b required 00000000/10", d, r);
    end
    axi_write(12'h000, 32'h1234_5678, 4'b1111, 1'b0, b);
    tests++;
    if (b !== 2'b10) begin
      fails++; $display("FAIL wr_readonly bresp=%b required 10", b);
    end
    axi_read(12'h000, d, r, lat);
    tests++;
    if (d !== 32'h00F5_0020) begin
      fails++; $display("FAIL rd_version_after_ro got=%h required 00f50020", d);
    end
  endtask

  task automatic test_round_time();
    logic [31:0] d; logic [1:0] r; int lat;
    round_time[63:0] = 64'h1111_2222_3333_4444;
    axi_read(12'h118, d, r, lat);
    tests++;
    if (d !== 32'h3333_4444) begin
      fails++; $display("FAIL rd_rt_lo got=%h required 33334444", d);
    end
    round_time[63:0] = 64'h5555_6666_7777_8888;
    axi_read(12'h11C, d, r, lat);
    tests++;
    if (d !== 32'h1111_2222) begin
      fails++; $display("FAIL rd_rt_hi got=%h required 11112222", d);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] d; logic [1:0] r, b; int lat;
    axi_write(12'h010, 32'h1, 4'b0001, 1'b0, b);
    @(negedge s_axi_aclk); bist_cplt[0] = 1'b1;
    @(negedge s_axi_aclk); bist_cplt[0] = 1'b0;
    tests++;
    if (usr_int_req !== 4'b0000) begin
      fails++; $display("FAIL int_lag got=%b required 0000", usr_int_req);
    end
    @(negedge s_axi_aclk);
    tests++;
    if (usr_int_req !== 4'b0001) begin
      fails++; $display("FAIL int_cplt got=%b required 0001", usr_int_req);
    end
    axi_write(12'h014, 32'h1, 4'b0001, 1'b0, b);
    @(negedge s_axi_aclk);
    tests++;
    if (usr_int_req !== 4'b0000) begin
      fails++; $display("FAIL int_w1c got=%b required 0000", usr_int_req);
    end
    @(negedge s_axi_aclk); bist_cplt[0] = 1'b1;
    @(negedge s_axi_aclk); bist_cplt[0] = 1'b0;
    @(negedge s_axi_aclk);
    tests++;
    if (usr_int_req !== 4'b0001) begin
      fails++; $display("FAIL int_cplt2 got=%b required 0001", usr_int_req);
    end
    usr_int_ack[0] = 1'b1;
    @(negedge s_axi_aclk); usr_int_ack[0] = 1'b0;
    @(negedge s_axi_aclk);
    tests++;
    if (usr_int_req !== 4'b0000) begin
      fails++; $display("FAIL int_ack got=%b required 0000", usr_int_req);
    end
    axi_write(12'h018, 32'h1, 4'b0001, 1'b0, b);
    @(negedge s_axi_aclk);
    tests++;
    if (usr_int_req !== 4'b0001) begin
      fails++; $display("FAIL int_force got=%b required 0001", usr_int_req);
    end
    axi_read(12'h018, d, r, lat);
    tests++;
    if (d !== 32'h0 || r !== 2'b00) begin
      fails++; $display("FAIL rd_int_force got=%h/%b required 0/00", d, r);
    end
    @(negedge s_axi_aclk); bist_err[2] = 1'b1;
    @(negedge s_axi_aclk); bist_err[2] = 1'b0;
    axi_read(12'h188, d, r, lat);
    tests++;
    if (d !== 32'h4) begin
      fails++; $display("FAIL rd_err_sticky got=%h required 00000004", d);
    end
    axi_write(12'h008, 32'h1, 4'b0001, 1'b0, b);
    axi_read(12'h188, d, r, lat);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL soft_clr_sticky got=%h required 0", d);
    end
    axi_read(12'h014, d, r, lat);
    tests++;
    if (d !== 32'h0 || usr_int_req !== 4'b0000) begin
      fails++; $display("FAIL soft_clr_int status=%h req=%b required 0/0000", d, usr_int_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r, b; int lat;
    axi_write(12'h01C, 32'hCAFE_0001, 4'b1111, 1'b0, b);
    axi_write(12'h01C, 32'h0000_BE00, 4'b0010, 1'b1, b);
    axi_read(12'h01C, d, r, lat);
    tests++;
    if (d !== 32'hCAFE_BE01) begin
      fails++; $display("FAIL b2b_scratch got=%h required cafebe01", d);
    end
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d; logic [1:0] r, b; int lat; int bad;
    s_axi_bready = 1'b0;
    axi_write(12'h01C, 32'h1234_5678, 4'b1111, 1'b0, b);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge s_axi_aclk);
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL b_hold bad_cycles=%0d required 0", bad);
    end
    axi_read(12'h01C, d, r, lat);
    tests++;
    if (d !== 32'h1234_5678 || r !== 2'b00 || s_axi_bvalid !== 1'b1) begin
      fails++; $display("FAIL rd_during_b got=%h/%b bvalid=%b required 12345678/00/1", d, r, s_axi_bvalid);
    end
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b0;
    #1;
    tests++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
      fails++; $display("FAIL async_reset bvalid=%b awready=%b wready=%b required 0/1/1",
        s_axi_bvalid, s_axi_awready, s_axi_wready);
    end
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    s_axi_bready = 1'b1;
    axi_read(12'h01C, d, r, lat);
    tests++;
    if (d !== 32'h0 || prbs_mode_start !== 4'b0000) begin
      fails++; $display("FAIL post_reset scratch=%h start=%b required 0/0000", d, prbs_mode_start);
    end
  endtask

  initial begin
    s_axi_aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    bist_running = '0; bist_cplt = '0; bist_err = '0;
    err_cnt = '0; txcmd_cnt = '0; rxcmd_cnt = '0; round_time = '0;
    ddr_cal_done = 1'b1; usr_int_ack = '0;
    repeat (3) @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
    test_reset();
    test_write_strobes();
    test_unmapped();
    test_round_time();
    test_interrupt();
    test_back_to_back();
    test_b_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
